recip_result_avg: RTL and testbench



---
 rtl/recip_pkg.sv | 18 +
 rtl/recip_minmax_track.sv | 37 +++
 rtl/recip_result_avg.sv | 96 +++++++++
 tb/tb_recip_result_avg.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recip_pkg.sv
// recip_pkg: shared FSM states, width helpers and saturating counter for recip_result_avg.
package recip_pkg;
    typedef enum logic [1:0] {S_WAIT_VALID, S_ACK, S_WAIT_DROP, S_OUTPUT} state_t;
    localparam int DEF_COARSE_WIDTH = 24;
    localparam int DEF_FINE_WIDTH = 8;
    localparam int DEF_AVG_LOG2 = 4;
    function automatic int sw_of(input int coarse_w, input int fine_w);
        return coarse_w + fine_w;
    endfunction
    function automatic int acc_w_of(input int coarse_w, input int fine_w, input int avg_log2);
        return coarse_w + fine_w + avg_log2;
    endfunction
    localparam int SW = sw_of(DEF_COARSE_WIDTH, DEF_FINE_WIDTH);
    localparam int ACC_W = acc_w_of(DEF_COARSE_WIDTH, DEF_FINE_WIDTH, DEF_AVG_LOG2);
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/recip_minmax_track.sv
// recip_minmax_track: running min/max of accepted samples, latched alongside the window mean.
module recip_minmax_track
    import recip_pkg::*;
#(
    parameter int W = SW
) (
    input  logic         clk_fast,
    input  logic         rst,
    input  logic         init,
    input  logic         upd,
    input  logic [W-1:0] sample,
    input  logic         latch,
    output logic [W-1:0] out_min,
    output logic [W-1:0] out_max
);
    logic [W-1:0] cur_min, cur_max;
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            cur_min <= '1;
            cur_max <= '0;
            out_min <= '0;
            out_max <= '0;
        end else begin
            if (latch) begin
                out_min <= cur_min;
                out_max <= cur_max;
            end
            if (init) begin
                cur_min <= '1;
                cur_max <= '0;
            end else if (upd) begin
                cur_min <= (sample < cur_min) ? sample : cur_min;
                cur_max <= (sample > cur_max) ? sample : cur_max;
            end
        end
    end
endmodule

// File: rtl/recip_result_avg.sv
// recip_result_avg: averages 2^AVG_LOG2 TDC results into a fixed-point mean on a valid/ready output.
// Define RECIP_AVG_MINMAX_EN to add per-window out_min/out_max.
module recip_result_avg
    import recip_pkg::*;
#(
    parameter int COARSE_WIDTH = DEF_COARSE_WIDTH,
    parameter int FINE_WIDTH   = DEF_FINE_WIDTH,
    parameter int USE_FINE     = 1,
    parameter int AVG_LOG2     = DEF_AVG_LOG2
) (
    input  logic                                clk_fast,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ack,
    input  logic [COARSE_WIDTH-1:0]             in_coarse,
    input  logic [FINE_WIDTH-1:0]               in_fine,
    input  logic                                clear,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [COARSE_WIDTH+FINE_WIDTH-1:0]  out_mean,
`ifdef RECIP_AVG_MINMAX_EN
    output logic [COARSE_WIDTH+FINE_WIDTH-1:0]  out_min,
    output logic [COARSE_WIDTH+FINE_WIDTH-1:0]  out_max,
`endif
    output logic [7:0]                          err_zero_cnt
);
    localparam int SMP_W = sw_of(COARSE_WIDTH, FINE_WIDTH);
    localparam int AW = acc_w_of(COARSE_WIDTH, FINE_WIDTH, AVG_LOG2);
    localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(1 << AVG_LOG2);
    state_t state, nxt;
    logic [AW-1:0] acc;
    logic [AVG_LOG2:0] cnt;
    logic [SMP_W-1:0] sample;
    logic take, zero, latch;
    assign sample = {in_coarse, (USE_FINE != 0) ? in_fine : {FINE_WIDTH{1'b0}}};
    assign zero = (state == S_ACK) && (in_coarse == '0);
    assign take = (state == S_ACK) && !clear && (in_coarse != '0);
    assign latch = (state == S_WAIT_DROP) && !in_valid && !clear && (cnt == FULL);
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) state <= S_WAIT_VALID;
        else state <= nxt;
    end
    // clear overrides every transition but still lets a running ack finish through S_WAIT_DROP
    always_comb begin
        nxt = state;
        if (clear) nxt = (state == S_ACK || state == S_WAIT_DROP) ? S_WAIT_DROP : S_WAIT_VALID;
        else begin
            case (state)
                S_WAIT_VALID: nxt = in_valid ? S_ACK : S_WAIT_VALID;
                S_ACK:        nxt = S_WAIT_DROP;
                S_WAIT_DROP:  nxt = in_valid ? S_WAIT_DROP : (cnt == FULL) ? S_OUTPUT : S_WAIT_VALID;
                default:      nxt = out_ready ? S_WAIT_VALID : S_OUTPUT;
            endcase
        end
    end
    always_comb in_ack = (state == S_ACK);
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            out_valid <= 1'b0;
            out_mean <= '0;
            err_zero_cnt <= '0;
        end else begin
            if (zero) err_zero_cnt <= sat_inc8(err_zero_cnt);
            if (clear) begin
                acc <= '0;
                cnt <= '0;
                out_valid <= 1'b0;
            end else if (latch) begin
                out_mean <= acc[AW-1:AVG_LOG2];
                out_valid <= 1'b1;
                acc <= '0;
                cnt <= '0;
            end else begin
                if (take) begin
                    acc <= acc + AW'(sample);
                    cnt <= cnt + (AVG_LOG2 + 1)'(1);
                end
                if (state == S_OUTPUT && out_ready) out_valid <= 1'b0;
            end
        end
    end
`ifdef RECIP_AVG_MINMAX_EN
    recip_minmax_track #(.W(SMP_W)) u_minmax (
        .clk_fast(clk_fast),
        .rst(rst),
        .init(clear | latch),
        .upd(take),
        .sample(sample),
        .latch(latch),
        .out_min(out_min),
        .out_max(out_max)
    );
`endif
endmodule

// File: tb/tb_recip_result_avg.sv
// tb_recip_result_avg: directed checks of recip_result_avg with AVG_LOG2=2, USE_FINE=0 and USE_FINE=1 side by side.
module tb_recip_result_avg;
    logic clk_fast = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;
    logic [23:0] in_coarse = '0;
    logic [7:0] in_fine = '0;
    logic ack0, ack1, ov0, ov1;
    logic [31:0] mean0, mean1;
    logic [7:0] err0, err1;
    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int dbl = 0;
    int ack_mis = 0;
    logic prev_ack = 1'b0;

    always #5 clk_fast = ~clk_fast;

    recip_result_avg #(.COARSE_WIDTH(24), .FINE_WIDTH(8), .USE_FINE(0), .AVG_LOG2(2)) dut0 (
        .clk_fast(clk_fast), .rst(rst), .in_valid(in_valid), .in_ack(ack0),
        .in_coarse(in_coarse), .in_fine(in_fine), .clear(clear), .out_valid(ov0),
        .out_ready(out_ready), .out_mean(mean0), .err_zero_cnt(err0)
    );
    recip_result_avg #(.COARSE_WIDTH(24), .FINE_WIDTH(8), .USE_FINE(1), .AVG_LOG2(2)) dut1 (
        .clk_fast(clk_fast), .rst(rst), .in_valid(in_valid), .in_ack(ack1),
        .in_coarse(in_coarse), .in_fine(in_fine), .clear(clear), .out_valid(ov1),
        .out_ready(out_ready), .out_mean(mean1), .err_zero_cnt(err1)
    );

    always @(negedge clk_fast) begin
        if (ack0) ack_cnt++;
        if (ack0 && prev_ack) dbl++;
        if (ack1 !== ack0) ack_mis++;
        prev_ack = ack0;
    end

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic send(input logic [23:0] c, input logic [7:0] f, input int hold, input bit clr);
        bit got = 1'b0;
        in_coarse = c;
        in_fine = f;
        in_valid = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = ack0;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_ack coarse=%0d got=0 want=1", c);
        end
        if (clr) clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (hold) tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL accept_drop out_valid=%b/%b want=0", ov0, ov1);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({ack0, ov0, mean0, err0} !== '0) begin
            failures++;
            $display("FAIL reset_dut0 ack=%b ov=%b mean=%0d err=%0d want all 0", ack0, ov0, mean0, err0);
        end
        checks++;
        if ({ack1, ov1, mean1, err1} !== '0) begin
            failures++;
            $display("FAIL reset_dut1 ack=%b ov=%b mean=%0d err=%0d want all 0", ack1, ov1, mean1, err1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_avg_coarse();
        int a = ack_cnt;
        send(24'd1000, 8'h40, 0, 0);
        send(24'd1002, 8'h40, 0, 0);
        send(24'd998, 8'h40, 0, 0);
        checks++;
        if (ov0 !== 1'b0) begin
            failures++;
            $display("FAIL avg_early ov=%b want=0", ov0);
        end
        send(24'd1000, 8'h40, 0, 0);
        checks++;
        if (ov0 !== 1'b1 || ov1 !== 1'b1) begin
            failures++;
            $display("FAIL avg_valid ov=%b/%b want=1", ov0, ov1);
        end
        checks++;
        if (mean0 !== 32'd256000) begin
            failures++;
            $display("FAIL avg_mean_nofine got=%0d want=256000", mean0);
        end
        checks++;
        if (mean1 !== 32'd256064) begin
            failures++;
            $display("FAIL avg_mean_fine got=%0d want=256064", mean1);
        end
        checks++;
        if (ack_cnt - a !== 4) begin
            failures++;
            $display("FAIL avg_ack_count got=%0d want=4", ack_cnt - a);
        end
        accept();
    endtask

    task automatic test_fine();
        send(24'd10, 8'd0, 0, 0);
        send(24'd10, 8'd64, 0, 0);
        send(24'd10, 8'd128, 0, 0);
        send(24'd10, 8'd192, 0, 0);
        checks++;
        if (mean1 !== 32'd2656 || ov1 !== 1'b1) begin
            failures++;
            $display("FAIL fine_mean got=%0d ov=%b want=2656 ov=1", mean1, ov1);
        end
        checks++;
        if (mean0 !== 32'd2560) begin
            failures++;
            $display("FAIL fine_forced_zero got=%0d want=2560", mean0);
        end
        accept();
    endtask

    task automatic test_slow_drop();
        int a = ack_cnt;
        send(24'd7, 8'd0, 5, 0);
        checks++;
        if (ack_cnt - a !== 1) begin
            failures++;
            $display("FAIL slow_drop_single got=%0d want=1", ack_cnt - a);
        end
        send(24'd7, 8'd0, 0, 0);
        send(24'd7, 8'd0, 2, 0);
        send(24'd7, 8'd0, 0, 0);
        checks++;
        if (ack_cnt - a !== 4 || mean0 !== 32'd1792) begin
            failures++;
            $display("FAIL slow_drop_window acks=%0d mean=%0d want 4 and 1792", ack_cnt - a, mean0);
        end
        accept();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bit got = 1'b0;
        logic [31:0] m;
        for (int i = 0; i < 4; i++) send(24'd20, 8'd0, 0, 0);
        m = mean0;
        in_coarse = 24'd30;
        in_fine = 8'd0;
        in_valid = 1'b1;
        repeat (20) begin
            tick();
            if (ack0 || mean0 !== m || !ov0) bad++;
        end
        checks++;
        if (bad !== 0 || m !== 32'd5120) begin
            failures++;
            $display("FAIL backpressure_hold bad_cycles=%0d mean=%0d want 0 and 5120", bad, m);
        end
        accept();
        for (int i = 0; i < 2 && !got; i++) begin
            if (i > 0) tick();
            got = ack0;
        end
        if (!got) tick();
        got = got | ack0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL backpressure_ack got=0 want=1");
        end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(24'd10, 8'd0, 0, 0);
        send(24'd0, 8'd0, 0, 0);
        send(24'd20, 8'd0, 0, 0);
        send(24'd30, 8'd0, 0, 0);
        checks++;
        if (err0 !== 8'd1 || err1 !== 8'd1) begin
            failures++;
            $display("FAIL zero_err got=%0d/%0d want=1", err0, err1);
        end
        checks++;
        if (ov0 !== 1'b0) begin
            failures++;
            $display("FAIL zero_no_output ov=%b want=0", ov0);
        end
        send(24'd40, 8'd0, 0, 0);
        checks++;
        if (ov0 !== 1'b1 || mean0 !== 32'd6400) begin
            failures++;
            $display("FAIL zero_mean ov=%b mean=%0d want 1 and 6400", ov0, mean0);
        end
        accept();
    endtask

    task automatic test_clear();
        send(24'd999, 8'd0, 0, 0);
        send(24'd999, 8'd0, 0, 0);
        send(24'd999, 8'd0, 0, 1);
        for (int i = 0; i < 3; i++) send(24'd500, 8'd0, 0, 0);
        checks++;
        if (ov0 !== 1'b0) begin
            failures++;
            $display("FAIL clear_early ov=%b want=0", ov0);
        end
        send(24'd500, 8'd0, 0, 0);
        checks++;
        if (ov0 !== 1'b1 || mean0 !== 32'd128000 || mean1 !== 32'd128000) begin
            failures++;
            $display("FAIL clear_mean ov=%b mean=%0d/%0d want 1 and 128000", ov0, mean0, mean1);
        end
        accept();
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        in_coarse = 24'd77;
        in_valid = 1'b1;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            got = ack0;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ack0, ov0, mean0, err0} !== '0 || {ack1, ov1, mean1, err1} !== '0) begin
            failures++;
            $display("FAIL reset_mid ack=%b ov=%b mean=%0d err=%0d want all 0", ack0, ov0, mean0, err0);
        end
        rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            tick();
            got = ack0;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL reset_recapture got=0 want=1");
        end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_avg_coarse();
        test_fine();
        test_slow_drop();
        test_backpressure();
        test_zero();
        test_clear();
        test_reset_mid();
        checks++;
        if (dbl !== 0 || ack_mis !== 0) begin
            failures++;
            $display("FAIL ack_pulse double=%0d diverge=%0d want 0", dbl, ack_mis);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
